wb_sequencer: RTL and testbench
===============================

Name: wb_sequencer

Overview:
Writeback-side producer for the register file write port (writeBackEn / destWB / resultWB).
- Normal mode: registers the MEM-stage result and selects the ALU or memory data.
- Block-load mode (LDM-style): sequences memory reads and writes one loaded word per cycle into the registers named in a 16-bit list.
- Stalls the pipeline while a block load runs.

Parameters:
DATA_W, 32, data/address width
REG_AW, 4, register index width
LIST_W, 16, register-list width (= 2**REG_AW)

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
wb_en_in  in  1  single writeback request from MEM stage
mem_r_en_in  in  1  1: write mem_data_in, 0: write alu_res_in
dest_in  in  REG_AW  single writeback destination
alu_res_in  in  DATA_W  ALU result
mem_data_in  in  DATA_W  load data
blk_start  in  1  start block load (sampled only in IDLE)
blk_list  in  LIST_W  register list, bit i = register i
blk_base  in  DATA_W  start address
blk_up  in  1  1: ascending, 0: descending
blk_busy  out  1  pipeline stall while sequencing
blk_done  out  1  one-cycle pulse at end of block load
mem_rd_req  out  1  memory read request
mem_rd_addr  out  DATA_W  read address, word aligned
mem_rd_ack  in  1  read data valid this cycle
mem_rd_data  in  DATA_W  read data
writeBackEn  out  1  register file write enable
destWB  out  REG_AW  register file write index
resultWB  out  DATA_W  register file write data

Behaviour:
- All outputs are registered.
- Reset values: writeBackEn=0, destWB=0, resultWB=0, mem_rd_req=0, mem_rd_addr=0, blk_busy=0, blk_done=0, state=IDLE, internal list=0.
- States: IDLE, REQ, DONE.
- IDLE, single path, latency 1 cycle:
  - writeBackEn <= wb_en_in; destWB <= dest_in.
  - resultWB <= mem_r_en_in ? mem_data_in : alu_res_in.
  - When wb_en_in=0, destWB and resultWB still update; only writeBackEn gates the write.
- IDLE and blk_start=1:
  - Single path is still honoured that same cycle.
  - If blk_list is nonzero: latch the list as remaining, addr <= blk_base, latch direction, blk_busy <= 1, go to REQ.
  - If blk_list is zero: no reads, no writes; blk_busy <= 1, go to DONE.
- REQ:
  - mem_rd_req=1; mem_rd_addr=addr, held stable until ack.
  - Current register: lowest set bit of remaining when ascending, highest set bit when descending.
  - On mem_rd_ack (ack allowed in the first REQ cycle):
    - Next cycle: writeBackEn=1, destWB=current register, resultWB=mem_rd_data.
    - Clear that bit from remaining.
    - addr <= addr+4 (ascending) or addr-4 (descending), modulo 2**DATA_W, no saturation.
    - If remaining becomes zero: mem_rd_req <= 0, go to DONE. Otherwise stay in REQ with mem_rd_req held at 1, giving back-to-back reads.
  - Without ack: writeBackEn=0, all else holds.
- Throughput: one register written per acked cycle, so N registers with ack always high take N REQ cycles.
- DONE (one cycle): blk_done=1, blk_busy <= 0, then IDLE. The final write (writeBackEn=1) appears in the DONE cycle.
- blk_busy is 1 from the cycle after blk_start through the DONE cycle inclusive.
- While blk_busy=1: wb_en_in, blk_start and the other single-path inputs are ignored; the pipeline is stalled.
- Register 15 in the list is written like any other register; no PC special case.
- Reset mid-block: abort immediately. No further writes, mem_rd_req drops, blk_done is not pulsed. A pending ack in the reset cycle is discarded.
- mem_rd_ack outside REQ is ignored.

Test Plan:
- Single writes: wb_en_in=1, mem_r_en_in=0, dest_in=3, alu_res_in=0x1234 -> next cycle writeBackEn=1, destWB=3, resultWB=0x1234. Then mem_r_en_in=1, mem_data_in=0xCAFE, dest_in=5 -> destWB=5, resultWB=0xCAFE.
- Ascending block: blk_list=0x0015, blk_base=0x100, blk_up=1, ack always high:
  - Reads at 0x100, 0x104, 0x108.
  - Writes to r0, r2, r4 with data 0xA0/0xA1/0xA2 on consecutive cycles.
  - blk_busy high for 4 cycles; blk_done pulses once.
- Descending with stalls: blk_list=0x8002, blk_base=0x200, blk_up=0, ack delayed 2 cycles per read:
  - mem_rd_addr holds 0x200, then 0x1FC.
  - Writes r15 then r1; no writeBackEn during wait cycles.
- Empty list: blk_start with blk_list=0 -> blk_busy 1 cycle, blk_done pulse, no mem_rd_req, no writeBackEn.
- Reset mid-block: blk_list=0xFFFF, rst asserted after 3 writes -> next cycle all outputs 0, no blk_done. A following single write works normally.
- Wrap and overlap:
  - blk_base=0xFFFFFFFC ascending, list=0x0003 -> second read at 0x00000000.
  - wb_en_in asserted while blk_busy=1 -> no single write occurs.

Source files
------------

// File: rtl/wb_sequencer.sv
// Writeback-side producer for the register file write port: registers single
// MEM-stage writebacks and sequences LDM-style block loads one word per cycle.
module wb_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int LIST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              blk_start,
  input  logic [LIST_W-1:0] blk_list,
  input  logic [DATA_W-1:0] blk_base,
  input  logic              blk_up,
  output logic              blk_busy,
  output logic              blk_done,
  output logic              mem_rd_req,
  output logic [DATA_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              writeBackEn,
  output logic [REG_AW-1:0] destWB,
  output logic [DATA_W-1:0] resultWB,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [LIST_W-1:0]   rem_q;
  logic                up_q;
  logic [DATA_W-1:0]   addr_q;
  logic                rd_req_q;
  logic                busy_q;
  logic                done_q;
  logic                wb_en_q;
  logic [REG_AW-1:0]   dest_q;
  logic [DATA_W-1:0]   result_q;

  logic [REG_AW-1:0]   cur_idx;
  logic [LIST_W-1:0]   rem_d;
  logic [DATA_W-1:0]   addr_d;

  // Ascending picks the lowest set bit, descending the highest: the loop keeps
  // overwriting, so the scan order decides which set bit wins.
  always_comb begin
    cur_idx = '0;
    if (up_q) begin
      for (int i = LIST_W - 1; i >= 0; i--) begin
        if (rem_q[i]) cur_idx = REG_AW'(i);
      end
    end else begin
      for (int i = 0; i < LIST_W; i++) begin
        if (rem_q[i]) cur_idx = REG_AW'(i);
      end
    end
    rem_d  = rem_q & ~(LIST_W'(1) << cur_idx);
    addr_d = up_q ? (addr_q + DATA_W'(4)) : (addr_q - DATA_W'(4));
  end

  // Read handshake: a word transfers in any cycle where mem_rd_req and
  // mem_rd_ack are both high; req and addr stay stable until that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      up_q     <= 1'b0;
      addr_q   <= '0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wb_en_q  <= 1'b0;
      dest_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wb_en_q  <= wb_en_in;
          dest_q   <= dest_in;
          result_q <= mem_r_en_in ? mem_data_in : alu_res_in;
          done_q   <= 1'b0;
          if (blk_start) begin
            busy_q <= 1'b1;
            if (|blk_list) begin
              rem_q    <= blk_list;
              addr_q   <= blk_base;
              up_q     <= blk_up;
              rd_req_q <= 1'b1;
              state_q  <= S_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_rd_ack) begin
            wb_en_q  <= 1'b1;
            dest_q   <= cur_idx;
            result_q <= mem_rd_data;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            if (rem_d == '0) begin
              rd_req_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end else begin
            wb_en_q <= 1'b0;
          end
        end
        S_DONE: begin
          wb_en_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign blk_busy    = busy_q;
  assign blk_done    = done_q;
  assign mem_rd_req  = rd_req_q;
  assign mem_rd_addr = addr_q;
  assign writeBackEn = wb_en_q;
  assign destWB      = dest_q;
  assign resultWB    = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: scoreboard of expected writes and read addresses,
// a memory responder with configurable ack delay, one task per scenario.
module tb_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0;
  logic        mem_r_en_in = 1'b0;
  logic [3:0]  dest_in = '0;
  logic [31:0] alu_res_in = '0;
  logic [31:0] mem_data_in = '0;
  logic        blk_start = 1'b0;
  logic [15:0] blk_list = '0;
  logic [31:0] blk_base = '0;
  logic        blk_up = 1'b0;
  logic        blk_busy;
  logic        blk_done;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        writeBackEn;
  logic [3:0]  destWB;
  logic [31:0] resultWB;
  logic [1:0]  dbg_state;

  wb_sequencer dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .dest_in(dest_in),
    .alu_res_in(alu_res_in), .mem_data_in(mem_data_in),
    .blk_start(blk_start), .blk_list(blk_list), .blk_base(blk_base), .blk_up(blk_up),
    .blk_busy(blk_busy), .blk_done(blk_done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .writeBackEn(writeBackEn), .destWB(destWB), .resultWB(resultWB),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int done_cnt = 0;
  int busy_cnt = 0;

  // memory responder
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] resp_val = '0;
  logic        force_ack = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_rd_req === 1'b1) begin
      if (wait_cnt >= ack_delay) begin
        mem_rd_ack  = 1'b1;
        mem_rd_data = resp_val;
        resp_val    = resp_val + 32'd1;
        wait_cnt    = 0;
      end else begin
        mem_rd_ack  = 1'b0;
        mem_rd_data = 32'hDEAD_BEEF;
        wait_cnt    = wait_cnt + 1;
      end
    end else begin
      mem_rd_ack  = force_ack;
      mem_rd_data = 32'hBAD0_0BAD;
      wait_cnt    = 0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [35:0] e;
    logic [31:0] ea;
    if (rst === 1'b0) begin
      if (blk_done === 1'b1) done_cnt++;
      if (blk_busy === 1'b1) busy_cnt++;
      if (mem_rd_req === 1'b1 && mem_rd_ack === 1'b1) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL rd_addr unexpected read at addr %h", mem_rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (mem_rd_addr !== ea) begin
            errors++;
            $display("FAIL rd_addr got %h expected %h", mem_rd_addr, ea);
          end
        end
      end
    end
    if (writeBackEn === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb unexpected write r%0d data %h", destWB, resultWB);
      end else begin
        e = exp_q.pop_front();
        if ({destWB, resultWB} !== e) begin
          errors++;
          $display("FAIL wb got r%0d data %h expected r%0d data %h",
                   destWB, resultWB, e[35:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_single(input logic we, input logic mr, input logic [3:0] d,
                              input logic [31:0] alu, input logic [31:0] md);
    wb_en_in    = we;
    mem_r_en_in = mr;
    dest_in     = d;
    alu_res_in  = alu;
    mem_data_in = md;
    if (we) exp_q.push_back({d, mr ? md : alu});
    step();
    wb_en_in = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got %0d writes %0d reads pending expected 0 0",
               name, exp_q.size(), exp_addr_q.size());
      exp_q.delete();
      exp_addr_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({writeBackEn, destWB, resultWB, mem_rd_req, mem_rd_addr, blk_busy, blk_done, dbg_state}
        !== '0) begin
      errors++;
      $display("FAIL reset got we=%b d=%h r=%h req=%b a=%h busy=%b done=%b st=%0d expected all 0",
               writeBackEn, destWB, resultWB, mem_rd_req, mem_rd_addr, blk_busy, blk_done, dbg_state);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    drive_single(1'b1, 1'b0, 4'd3, 32'h1234, 32'h0);
    drive_single(1'b1, 1'b1, 4'd5, 32'h9999, 32'hCAFE);
    // back to back with random payloads
    for (int i = 0; i < 4; i++)
      drive_single(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom, $urandom);
    // disabled write still updates dest/result
    drive_single(1'b0, 1'b0, 4'd11, 32'h0BAD_F00D, 32'h0);
    checks++;
    if (writeBackEn !== 1'b0 || destWB !== 4'd11 || resultWB !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL single_nowe got we=%b d=%0d r=%h expected 0 11 0badf00d",
               writeBackEn, destWB, resultWB);
    end
    step();
    check_drained("single");
  endtask

  // runs one block load; noise keeps wb_en_in and blk_start high while busy
  task automatic run_block(input string name, input logic [15:0] list,
                           input logic [31:0] base, input logic up, input int delay,
                           input logic [31:0] data0, input logic noise);
    int k = 0;
    int nregs = 0;
    int d0, b0, exp_busy;
    bit seen = 0;
    for (int j = 0; j < 16; j++) begin
      int i = up ? j : 15 - j;
      if (list[i]) begin
        exp_addr_q.push_back(up ? base + 32'(4 * k) : base - 32'(4 * k));
        exp_q.push_back({4'(i), data0 + 32'(k)});
        k++;
      end
    end
    nregs    = k;
    exp_busy = nregs * (delay + 1) + 1;
    ack_delay = delay;
    resp_val  = data0;
    d0 = done_cnt;
    b0 = busy_cnt;
    blk_list  = list;
    blk_base  = base;
    blk_up    = up;
    blk_start = 1'b1;
    step();
    if (noise) begin
      wb_en_in   = 1'b1;
      dest_in    = 4'd7;
      alu_res_in = 32'h777;
    end else begin
      blk_start = 1'b0;
    end
    checks++;
    if (blk_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_start got %b expected 1", name, blk_busy);
    end
    for (int c = 0; c < 200; c++) begin
      if (blk_done === 1'b1) begin
        seen = 1;
        break;
      end
      step();
    end
    blk_start = 1'b0;
    wb_en_in  = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout got no blk_done expected pulse within 200 cycles", name);
    end
    step();
    checks++;
    if (blk_busy !== 1'b0 || blk_done !== 1'b0 || dbg_state !== 2'd0 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_end got busy=%b done=%b st=%0d req=%b expected 0 0 0 0",
               name, blk_busy, blk_done, dbg_state, mem_rd_req);
    end
    step();
    checks++;
    if (done_cnt - d0 != 1 || busy_cnt - b0 != exp_busy) begin
      errors++;
      $display("FAIL %s_counts got done=%0d busy=%0d expected 1 %0d",
               name, done_cnt - d0, busy_cnt - b0, exp_busy);
    end
    check_drained(name);
  endtask

  task automatic test_reset_mid_block();
    int d0 = done_cnt;
    ack_delay = 0;
    resp_val  = 32'h300;
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'h400 + 32'(4 * i));
      exp_q.push_back({4'(i), 32'h300 + 32'(i)});
    end
    blk_list  = 16'hFFFF;
    blk_base  = 32'h400;
    blk_up    = 1'b1;
    blk_start = 1'b1;
    step();
    blk_start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({writeBackEn, destWB, resultWB, mem_rd_req, mem_rd_addr, blk_busy, blk_done, dbg_state}
        !== '0) begin
      errors++;
      $display("FAIL rst_mid got we=%b d=%h r=%h req=%b a=%h busy=%b done=%b st=%0d expected all 0",
               writeBackEn, destWB, resultWB, mem_rd_req, mem_rd_addr, blk_busy, blk_done, dbg_state);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL rst_mid_done got %0d pulses expected 0", done_cnt - d0);
    end
    check_drained("rst_mid");
    drive_single(1'b1, 1'b0, 4'd9, 32'h55, 32'h0);
    step();
    check_drained("rst_after_single");
  endtask

  task automatic test_ack_outside_req();
    force_ack = 1'b1;
    repeat (3) step();
    force_ack = 1'b0;
    step();
    checks++;
    if (dbg_state !== 2'd0 || writeBackEn !== 1'b0 || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle got st=%0d we=%b req=%b expected 0 0 0",
               dbg_state, writeBackEn, mem_rd_req);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    run_block("asc",    16'h0015, 32'h100,       1'b1, 0, 32'hA0, 1'b0);
    run_block("desc",   16'h8002, 32'h200,       1'b0, 2, 32'hB0, 1'b0);
    run_block("empty",  16'h0000, 32'h500,       1'b1, 0, 32'hC0, 1'b0);
    test_reset_mid_block();
    run_block("wrap",   16'h0003, 32'hFFFF_FFFC, 1'b1, 0, 32'hD0, 1'b1);
    run_block("rand",   16'($urandom_range(1, 16'hFFFF)), 32'h1000, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 32'hE00, 1'b0);
    test_ack_outside_req();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
